// File: rtl/mmio_bus_decoder.sv
// Registered MMIO address decoder: maps LSU requests onto N_SLV base/mask regions,
// runs a req/ack handshake with slave wait states, timeout, error response and fault capture.
module mmio_bus_decoder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int N_SLV   = 7,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {
        32'h1001_0000, 32'h1000_4000, 32'h1000_3000, 32'h1000_2000,
        32'h1000_1000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {{6{32'hFFFF_F000}}, 32'hFFFF_F800},
    parameter int TIMEOUT = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic [DATA_W/8-1:0]     i_wstrb,
    output logic                    o_ack,
    output logic                    o_err,
    output logic [DATA_W-1:0]       o_rdata,
    output logic [N_SLV-1:0]        o_slv_sel,
    output logic                    o_slv_we,
    output logic [ADDR_W-1:0]       o_slv_addr,
    output logic [DATA_W-1:0]       o_slv_wdata,
    output logic [DATA_W/8-1:0]     o_slv_wstrb,
    input  logic [N_SLV-1:0]        i_slv_ack,
    input  logic [N_SLV*DATA_W-1:0] i_slv_rdata,
    output logic                    o_fault_valid,
    output logic [ADDR_W-1:0]       o_fault_addr,
    output logic                    o_fault_cause,
    input  logic                    i_fault_clr,
    output logic [1:0]              o_dbg_state
);

    // Handshake: the master raises i_req with stable fields and keeps them until
    // o_ack; o_ack is a single-cycle strobe qualifying o_err and o_rdata.

    localparam int IDX_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_n;

    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;
    logic               sel_ack;
    logic [DATA_W-1:0]  sel_rdata;

    logic               latch;
    logic               to_resp;
    logic               resp_err;
    logic [DATA_W-1:0]  resp_data;
    logic               fault_new;
    logic               fault_cause_n;
    logic [ADDR_W-1:0]  fault_addr_n;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if ((i_addr & SLV_MASK[k*ADDR_W +: ADDR_W]) == SLV_BASE[k*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    assign sel_ack   = i_slv_ack[idx_q];
    assign sel_rdata = i_slv_rdata[32'(idx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_n       = state;
        cnt_n         = cnt_q;
        latch         = 1'b0;
        to_resp       = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;
        fault_new     = 1'b0;
        fault_cause_n = 1'b0;
        fault_addr_n  = addr_q;
        unique case (state)
            IDLE: begin
                if (i_req) begin
                    if (hit_any) begin
                        latch   = 1'b1;
                        cnt_n   = '0;
                        state_n = ACCESS;
                    end else begin
                        to_resp      = 1'b1;
                        resp_err     = 1'b1;
                        fault_new    = 1'b1;
                        fault_addr_n = i_addr;
                        state_n      = RESP;
                    end
                end
            end
            ACCESS: begin
                // An ack arriving on the expiry cycle is still honoured.
                if (sel_ack) begin
                    to_resp   = 1'b1;
                    resp_data = o_slv_we ? '0 : sel_rdata;
                    cnt_n     = '0;
                    state_n   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    to_resp       = 1'b1;
                    resp_err      = 1'b1;
                    fault_new     = 1'b1;
                    fault_cause_n = 1'b1;
                    cnt_n         = '0;
                    state_n       = RESP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            cnt_q <= cnt_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q       <= '0;
            addr_q      <= '0;
            o_slv_sel   <= '0;
            o_slv_we    <= 1'b0;
            o_slv_addr  <= '0;
            o_slv_wdata <= '0;
            o_slv_wstrb <= '0;
        end else if (latch) begin
            idx_q       <= hit_idx;
            addr_q      <= i_addr;
            o_slv_sel   <= N_SLV'(1) << hit_idx;
            o_slv_we    <= i_we;
            o_slv_addr  <= i_addr & ~SLV_MASK[32'(hit_idx)*ADDR_W +: ADDR_W];
            o_slv_wdata <= i_wdata;
            o_slv_wstrb <= STRB_W'(i_wstrb);
        end else if (to_resp) begin
            o_slv_sel <= '0;
        end
    end

    // Response outputs are registered so o_ack/o_err/o_rdata cannot glitch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_ack   <= to_resp;
            o_err   <= resp_err;
            o_rdata <= resp_data;
        end
    end

    // First fault wins; a clear coinciding with a new fault still records it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fault_valid <= 1'b0;
            o_fault_addr  <= '0;
            o_fault_cause <= 1'b0;
        end else if (fault_new && (!o_fault_valid || i_fault_clr)) begin
            o_fault_valid <= 1'b1;
            o_fault_addr  <= fault_addr_n;
            o_fault_cause <= fault_cause_n;
        end else if (i_fault_clr) begin
            o_fault_valid <= 1'b0;
        end
    end

    assign o_dbg_state = state;

endmodule
